vga_mem_reader: RTL and testbench
=================================

# vga_mem_reader

Sequential fetch engine that reads a block of 16-bit words from the VGA frame memory and streams them to a downstream consumer (pixel serializer or LCD text path). It is the read side of the VGA memory port: the memory copy path writes words in, and this block scans them out. It issues one read per cycle while credit exists, absorbs the 1-cycle synchronous-read latency in a small FIFO, and presents data through a valid/ready handshake.

## Interface
- ADDR_W, 15, memory address width
- DATA_W, 16, memory/stream data width
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches base and len, begins fetch
- base  in  ADDR_W  first word address
- len  in  ADDR_W+1  number of words to read (0 allowed)
- abort  in  1  cancel current transfer, flush FIFO
- mem_en  out  1  memory read enable (registered)
- mem_addr  out  ADDR_W  memory read address (registered)
- mem_dout  in  DATA_W  memory read data, valid one cycle after mem_en sampled
- out_data  out  DATA_W  stream word (FIFO head)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when last word is accepted downstream

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: start with len≠0 → latch base into address counter, len into remaining counter, go FETCH. start with len=0 → done pulses next cycle, stay IDLE, no reads. start while busy ignored.
- FETCH: issue read (mem_en=1, mem_addr=counter) when fifo_count + inflight < FIFO_DEPTH; each issue increments address (mod 2^ADDR_W, wraps 0x7FFF→0x0000) and decrements remaining. remaining reaches 0 → DRAIN.
- inflight: 1 when mem_en was asserted the previous cycle; returning mem_dout always pushed into FIFO. Credit rule guarantees FIFO never overflows.
- DRAIN: no reads; when FIFO empty, inflight 0 and last word handshaken → done pulse, IDLE.
- FIFO push and pop in same cycle: count unchanged, order preserved.
- abort (any state): next cycle IDLE, FIFO cleared, out_valid 0, in-flight return discarded, no done pulse. abort has priority over simultaneous start.
- Reset values: mem_en 0, mem_addr 0, out_valid 0, out_data 0, busy 0, done 0, state IDLE.

## Timing
- start sampled at edge T0 → mem_en/mem_addr=base valid after T0, memory samples at T1, word captured at T2, out_valid high after T2 (2-cycle start-to-data latency).
- With out_ready held high: one word per cycle sustained, len words accepted in cycles T2+1 … T2+len.
- out_ready low: FIFO fills to FIFO_DEPTH, issuing stops; resumes the cycle after a pop frees credit.
- done asserted the cycle after the final handshake; busy falls together with done.

## Configuration
- VGA_READER_WRAP_EN defined: continuous frame mode; on reaching remaining=0 the address reloads the latched base and remaining reloads len with no gap cycle; done pulses at each frame end; only abort returns to IDLE.
- Undefined: single pass as described above.

## Structure
- Shared package vga_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, FETCH, DRAIN).
- One sub-module: sync_fifo (parameterised width/depth, push/pop/count/empty/full), reusable elsewhere.

## Test plan
- start, base=0x0010, len=4, out_ready=1, memory holds addr+0x1000 → words 0x1010..0x1013 in order, first out_valid 2 cycles after start, done one cycle after last.
- len=0 → no mem_en ever, done one cycle after start, busy stays 0.
- base=0x7FFE, len=4 → addresses 0x7FFE,0x7FFF,0x0000,0x0001.
- len=16, out_ready low 10 cycles → exactly FIFO_DEPTH reads issued, no data lost; release → all 16 words in order.
- abort mid-FETCH with FIFO non-empty → out_valid 0 next cycle, no done, new start fetches cleanly.
- VGA_READER_WRAP_EN, len=3, base=5 → address sequence 5,6,7,5,6,7…, done every 3 accepted words.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared defaults and the reader state type for the VGA memory port.
package vga_pkg;

  localparam int VGA_ADDR_W = 15;
  localparam int VGA_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two depth, with a synchronous clear.
// Pushes are refused when full unless a pop happens in the same cycle; pops are
// refused when empty. Head data is presented combinationally from storage.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty    = (count_r == {CNT_W{1'b0}});
  assign full     = (count_r == CNT_W'(DEPTH));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Qualify push/pop against the current fill level.
  always_comb begin
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
  end

  // Storage, pointers and fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vga_mem_reader.sv
// vga_mem_reader: scans a block of words out of the VGA frame memory and
// streams them over a valid/ready interface.
// Build option: define VGA_READER_WRAP_EN for continuous frame mode (the block
// is re-read forever, done pulsing at each frame end, until abort).
//
// Credit: a read is issued only if every word already owed to the consumer
// (FIFO contents + word returning this edge + read the memory is sampling now),
// less any word popped this edge, leaves room in the FIFO. This is what lets the
// memory's one-cycle read latency be absorbed without ever overflowing.
module vga_mem_reader
  import vga_pkg::*;
#(
  parameter int ADDR_W     = VGA_ADDR_W,
  parameter int DATA_W     = VGA_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W - 1){1'b0}}, 1'b1};

`ifdef VGA_READER_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  vga_state_e        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   remaining_r;
  logic [ADDR_W:0]   acc_cnt_r;
  logic              inflight_r;
  logic              mem_en_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              busy_r;
  logic              done_r;

  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [DATA_W-1:0] fifo_data_s;
  logic              pop_s;
  logic [OCC_W-1:0]  occ_s;
  logic              issue_s;

  assign mem_en    = mem_en_r;
  assign mem_addr  = mem_addr_r;
  assign out_valid = ~fifo_empty_s;
  assign out_data  = fifo_data_s;
  assign busy      = busy_r;
  assign done      = done_r;

  // Output word buffer; returning read data is always pushed unless aborting.
  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort),
    .push      (inflight_r),
    .push_data (mem_dout),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // Downstream handshake and read-issue credit decision.
  always_comb begin
    pop_s = out_valid & out_ready;
    occ_s = OCC_W'(fifo_count_s) + OCC_W'(inflight_r) + OCC_W'(mem_en_r);
    if (pop_s) begin
      occ_s = occ_s - OCC_W'(1);
    end else begin
      occ_s = occ_s;
    end
    if ((state_r == FETCH) && (occ_s < OCC_W'(FIFO_DEPTH))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Transfer FSM: address/remaining counters, read issue, busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      base_r      <= {ADDR_W{1'b0}};
      len_r       <= LEN_ZERO;
      remaining_r <= LEN_ZERO;
      acc_cnt_r   <= LEN_ZERO;
      inflight_r  <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (abort) begin
      state_r    <= IDLE;
      inflight_r <= 1'b0;
      mem_en_r   <= 1'b0;
      acc_cnt_r  <= LEN_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      inflight_r <= mem_en_r;
      mem_en_r   <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (len == LEN_ZERO) begin
              done_r <= 1'b1;
            end else begin
              // First read goes out immediately; nothing is owed in IDLE.
              base_r     <= base;
              len_r      <= len;
              acc_cnt_r  <= LEN_ZERO;
              busy_r     <= 1'b1;
              mem_en_r   <= 1'b1;
              mem_addr_r <= base;
              if ((len == LEN_ONE) && WRAP_EN) begin
                addr_r      <= base;
                remaining_r <= len;
                state_r     <= FETCH;
              end else if (len == LEN_ONE) begin
                addr_r      <= base + ADDR_ONE;
                remaining_r <= LEN_ZERO;
                state_r     <= DRAIN;
              end else begin
                addr_r      <= base + ADDR_ONE;
                remaining_r <= len - LEN_ONE;
                state_r     <= FETCH;
              end
            end
          end
        end
        FETCH: begin
          if (issue_s) begin
            mem_en_r   <= 1'b1;
            mem_addr_r <= addr_r;
            if ((remaining_r == LEN_ONE) && WRAP_EN) begin
              addr_r      <= base_r;
              remaining_r <= len_r;
            end else if (remaining_r == LEN_ONE) begin
              addr_r      <= addr_r + ADDR_ONE;
              remaining_r <= LEN_ZERO;
              state_r     <= DRAIN;
            end else begin
              addr_r      <= addr_r + ADDR_ONE;
              remaining_r <= remaining_r - LEN_ONE;
            end
          end
        end
        DRAIN: begin
          state_r <= DRAIN;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      // Count accepted words; the len-th acceptance ends the frame.
      if ((state_r != IDLE) && pop_s) begin
        if (acc_cnt_r == (len_r - LEN_ONE)) begin
          acc_cnt_r <= LEN_ZERO;
          done_r    <= 1'b1;
          if (!WRAP_EN) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end else begin
          acc_cnt_r <= acc_cnt_r + LEN_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_mem_reader.sv
// tb_vga_mem_reader: directed bench with an address/data scoreboard.
// Build option: VGA_READER_WRAP_EN selects the continuous-frame test sequence.
module tb_vga_mem_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] base;
  logic [15:0] len;
  logic        abort;
  logic        mem_en;
  logic [14:0] mem_addr;
  logic [15:0] mem_dout = 16'h0000;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [14:0] addr_q [$];
  logic [15:0] data_q [$];

  int rd_count = 0;
  int hs_count = 0;
  int done_count = 0;
  int last_hs_edge = 0;
  int done_cyc = 0;
  int done_hs_edge = 0;
  int hs_at_done = 0;
  int first_valid_cyc = -1;
  logic busy_at_done = 1'b0;
  logic busy_seen = 1'b0;

  int t0, prev_d, prev_hs, prev_rd;

  vga_mem_reader #(.ADDR_W(15), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .len       (len),
    .abort     (abort),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory: word at addr is addr + 0x1000.
  always @(posedge clk) begin
    if (mem_en) mem_dout <= {1'b0, mem_addr} + 16'h1000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard addresses and stream words, record event cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_seen = 1'b1;
      if (done) begin
        done_count++;
        done_cyc     = cyc;
        done_hs_edge = last_hs_edge;
        hs_at_done   = hs_count;
        busy_at_done = busy;
      end
      if (mem_en) begin
        rd_count++;
        chk("addr_expected", 32'(addr_q.size() > 0), 32'd1);
        if (addr_q.size() > 0) chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        hs_count++;
        last_hs_edge = cyc + 1;
        chk("data_expected", 32'(data_q.size() > 0), 32'd1);
        if (data_q.size() > 0) chk("out_data", 32'(out_data), 32'(data_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [14:0] b, input logic [15:0] l);
    logic [14:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 15'(i);
      addr_q.push_back(a);
      data_q.push_back({1'b0, a} + 16'h1000);
    end
  endtask

  task automatic do_start(input logic [14:0] b, input logic [15:0] l, output int ts);
    base  = b;
    len   = l;
    start = 1'b1;
    ts    = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n_prev);
    int k;
    k = 0;
    while (done_count == n_prev && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_count > n_prev), 32'd1);
  endtask

  task automatic run_basic(input string tag, input logic [14:0] b, input logic [15:0] l);
    prev_d  = done_count;
    prev_hs = hs_count;
    prev_rd = rd_count;
    first_valid_cyc = -1;
    push_exp(b, l);
    do_start(b, l, t0);
    wait_done(tag, prev_d);
    chk({tag, "_latency"}, 32'(first_valid_cyc - t0), 32'd2);
    chk({tag, "_done_timing"}, 32'(done_cyc), 32'(done_hs_edge));
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_words"}, 32'(hs_count - prev_hs), 32'(l));
    chk({tag, "_reads"}, 32'(rd_count - prev_rd), 32'(l));
    chk({tag, "_sb_empty"}, 32'(data_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base = 15'h0000; len = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) step();

`ifdef VGA_READER_WRAP_EN
    // Continuous frames: base 5, len 3.
    for (int f = 0; f < 8; f++) push_exp(15'h0005, 16'd3);
    prev_hs = hs_count;
    prev_d  = done_count;
    do_start(15'h0005, 16'd3, t0);
    for (int f = 0; f < 4; f++) begin
      wait_done("wrap", prev_d + f);
      chk("wrap_words_per_done", 32'(hs_at_done - prev_hs), 32'(3 * (f + 1)));
      chk("wrap_busy", 32'(busy), 32'd1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("wrap_abort_valid", 32'(out_valid), 32'd0);
    chk("wrap_abort_busy", 32'(busy), 32'd0);
    addr_q.delete();
    data_q.delete();
    repeat (3) step();
`else
    // Basic transfer.
    run_basic("basic", 15'h0010, 16'd4);
    repeat (2) step();

    // Zero-length transfer.
    prev_d  = done_count;
    prev_rd = rd_count;
    busy_seen = 1'b0;
    do_start(15'h0040, 16'd0, t0);
    wait_done("len0", prev_d);
    chk("len0_done_timing", 32'(done_cyc), 32'(t0));
    repeat (3) step();
    chk("len0_reads", 32'(rd_count - prev_rd), 32'd0);
    chk("len0_busy", 32'(busy_seen), 32'd0);
    chk("len0_single_done", 32'(done_count - prev_d), 32'd1);

    // Address wrap at the top of memory.
    run_basic("wrap_addr", 15'h7FFE, 16'd4);
    repeat (2) step();

    // Backpressure: consumer stalls, fetch must stop at FIFO depth.
    out_ready = 1'b0;
    prev_d  = done_count;
    prev_hs = hs_count;
    prev_rd = rd_count;
    push_exp(15'h0300, 16'd16);
    do_start(15'h0300, 16'd16, t0);
    repeat (10) step();
    chk("bp_reads_capped", 32'(rd_count - prev_rd), 32'd4);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_done("bp", prev_d);
    chk("bp_words", 32'(hs_count - prev_hs), 32'd16);
    chk("bp_reads", 32'(rd_count - prev_rd), 32'd16);
    chk("bp_done_timing", 32'(done_cyc), 32'(done_hs_edge));
    chk("bp_sb_empty", 32'(data_q.size()), 32'd0);
    repeat (2) step();

    // Abort mid-fetch with a non-empty FIFO, then a clean restart.
    out_ready = 1'b0;
    prev_rd = rd_count;
    push_exp(15'h0100, 16'd16);
    do_start(15'h0100, 16'd16, t0);
    repeat (8) step();
    chk("abort_pre_valid", 32'(out_valid), 32'd1);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    prev_d = done_count;
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    addr_q.delete();
    data_q.delete();
    repeat (5) step();
    chk("abort_no_done", 32'(done_count - prev_d), 32'd0);
    chk("abort_no_reads", 32'(addr_q.size()), 32'd0);
    out_ready = 1'b1;
    run_basic("restart", 15'h0200, 16'd3);
    repeat (2) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
